// File: rtl/bm_dag_log_pipe_if.sv
// Handshake/data bundle for bm_dag_log_pipe; master drives transactions, slave is the pipe.
// Optional out_par exists only when DAG_LOG_PARITY_EN is defined.
interface bm_dag_log_pipe_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CWIDTH  = 1,
    parameter int unsigned COUNT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [CWIDTH-1:0]  c_in;
    logic [CWIDTH-1:0]  d_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out0;
    logic [CWIDTH-1:0]  out1;
    logic [COUNT_W-1:0] xfer_cnt;
`ifdef DAG_LOG_PARITY_EN
    logic               out_par;
`endif

    modport master (
        output in_valid, op_sel, a_in, b_in, c_in, d_in, out_ready,
        input  in_ready, out_valid, out0, out1, xfer_cnt
`ifdef DAG_LOG_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  in_valid, op_sel, a_in, b_in, c_in, d_in, out_ready,
        output in_ready, out_valid, out0, out1, xfer_cnt
`ifdef DAG_LOG_PARITY_EN
        , output out_par
`endif
    );
endinterface

// File: rtl/bm_dag_log_pipe.sv
// Two logic cones feeding a 2-stage valid/ready pipeline with op select and a wrapping transfer counter.
// Define DAG_LOG_PARITY_EN to add the registered out_par = ^{out0,out1} output.
module bm_dag_log_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CWIDTH  = 1,
    parameter int unsigned COUNT_W = 4
) (
    input logic clock,
    input logic reset_n,
    bm_dag_log_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    function automatic logic [WIDTH-1:0] op_eval(op_e op, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_XNOR: r = ~(x ^ y);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [CWIDTH-1:0]  p_q, p_d, q_q, q_d;
    op_e                op_q, op_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out0_q, out0_d;
    logic [CWIDTH-1:0]  out1_q, out1_d;
    logic [COUNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
`ifdef DAG_LOG_PARITY_EN
    logic               out_par_q, out_par_d;
`endif

    logic s2_free, s1_adv, in_ready, accept, out_xfer;

    always_comb begin
        s2_free  = !out_valid_q || bus.out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        accept   = bus.in_valid && in_ready;
        out_xfer = out_valid_q && bus.out_ready;

        s1_valid_d  = s1_valid_q;
        x_d         = x_q;
        y_d         = y_q;
        p_d         = p_q;
        q_d         = q_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        xfer_cnt_d  = xfer_cnt_q;
`ifdef DAG_LOG_PARITY_EN
        out_par_d   = out_par_q;
`endif

        // A new accept refills stage 1 in the same cycle its old contents advance.
        if (accept) begin
            s1_valid_d = 1'b1;
            x_d        = bus.a_in & bus.b_in;
            y_d        = (bus.a_in | bus.b_in) ^ bus.a_in;
            p_d        = (bus.c_in & bus.d_in) ^ bus.d_in;
            q_d        = (bus.c_in ^ bus.d_in) | bus.d_in;
            op_d       = op_e'(bus.op_sel);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            out0_d      = op_eval(op_q, x_q, y_q);
            out1_d      = p_q | q_q;
`ifdef DAG_LOG_PARITY_EN
            out_par_d   = ^{out0_d, out1_d};
`endif
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (out_xfer) begin
            xfer_cnt_d = xfer_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            op_q        <= OP_AND;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            xfer_cnt_q  <= '0;
`ifdef DAG_LOG_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            p_q         <= p_d;
            q_q         <= q_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            xfer_cnt_q  <= xfer_cnt_d;
`ifdef DAG_LOG_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.xfer_cnt  = xfer_cnt_q;
`ifdef DAG_LOG_PARITY_EN
    assign bus.out_par   = out_par_q;
`endif

endmodule
